// File: rtl/umem_pkg.sv
// umem_pkg: shared types and address-slice constants for the unified memory arbiter
package umem_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } rsp_own_t;
  localparam int WORD_LSB = 2;
endpackage

// File: rtl/umem_arb_sel.sv
// umem_arb_sel: one-hot priority select, write > forced fetch > data read > fetch
module umem_arb_sel (
  input  logic if_req,
  input  logic d_re,
  input  logic d_we,
  input  logic starve,
  output logic if_gnt,
  output logic d_rgnt,
  output logic d_wgnt
);
  logic force_if;
  // fetch only jumps ahead of data reads once starved; writes always win
  always_comb begin
    force_if = starve & if_req;
    d_wgnt = d_we;
    d_rgnt = ~d_we & d_re & ~force_if;
    if_gnt = ~d_we & if_req & (force_if | ~d_re);
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port SRAM between fetch and data ports
module unified_mem_arbiter
  import umem_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_re,
  input  logic [31:0]       d_raddr,
  output logic              d_rgnt,
  input  logic              d_we,
  input  logic [31:0]       d_waddr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_wgnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  rsp_own_t rsp_own;
  logic [CW-1:0] starve_cnt;
  logic starve;
  logic unused_addr_bits;
  assign starve = starve_cnt == SMAX;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+WORD_LSB], if_addr[WORD_LSB-1:0],
                              d_raddr[31:ADDR_W+WORD_LSB], d_raddr[WORD_LSB-1:0],
                              d_waddr[31:ADDR_W+WORD_LSB], d_waddr[WORD_LSB-1:0]};
  umem_arb_sel u_sel (
    .if_req (if_req & ~rst),
    .d_re   (d_re & ~rst),
    .d_we   (d_we & ~rst),
    .starve (starve),
    .if_gnt (if_gnt),
    .d_rgnt (d_rgnt),
    .d_wgnt (d_wgnt)
  );
  // SRAM port follows whichever requester holds the grant
  always_comb begin
    ram_en = if_gnt | d_rgnt | d_wgnt;
    ram_we = d_wgnt ? d_wstrb : 4'b0000;
    ram_wdata = d_wdata;
    ram_addr = d_wgnt ? d_waddr[ADDR_W+WORD_LSB-1:WORD_LSB] :
               d_rgnt ? d_raddr[ADDR_W+WORD_LSB-1:WORD_LSB] :
                        if_addr[ADDR_W+WORD_LSB-1:WORD_LSB];
    if_rvalid = (rsp_own == OWN_IF) & ~if_flush;
    d_rvalid = rsp_own == OWN_D;
    if_rdata = ram_rdata;
    d_rdata = ram_rdata;
  end
  // remember who owns next cycle's read data; writes and idle produce none
  always_ff @(posedge clk) begin
    if (rst) rsp_own <= OWN_NONE;
    else rsp_own <= if_gnt ? OWN_IF : d_rgnt ? OWN_D : OWN_NONE;
  end
  // count consecutive refused fetch cycles, saturating at the force threshold
  always_ff @(posedge clk) begin
    if (rst || !if_req || if_gnt) starve_cnt <= '0;
    else if (!starve) starve_cnt <= starve_cnt + 1'b1;
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: vector table plus response scoreboard for the arbiter
module tb_unified_mem_arbiter;
  typedef struct {
    logic r, ir; logic [31:0] ia; logic fl, dr; logic [31:0] ra;
    logic dw; logic [31:0] wa, wd; logic [3:0] ws;
    logic [2:0] g; logic [3:0] we; logic [13:0] ad;
  } vec_t;
  typedef struct { logic [1:0] own; logic [31:0] data; } rsp_t;

  logic clk = 0, rst = 0, if_req = 0, if_flush = 0, d_re = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_raddr = 0, d_waddr = 0, d_wdata = 0;
  logic [3:0] d_wstrb = 0;
  logic if_gnt, if_rvalid, d_rgnt, d_wgnt, d_rvalid, ram_en;
  logic [31:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
  logic [3:0] ram_we;
  logic [13:0] ram_addr;
  int total = 0, bad = 0;
  logic [31:0] mem [0:16383];
  logic [31:0] shadow [int];
  rsp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(14), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_re(d_re), .d_raddr(d_raddr), .d_rgnt(d_rgnt), .d_we(d_we), .d_waddr(d_waddr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wgnt(d_wgnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 32'h20) ? 32'h11223344 : {8'hA5, 8'h00, 16'(i)};
  endfunction

  function automatic logic [31:0] exp_word(int i);
    return shadow.exists(i) ? shadow[i] : init_word(i);
  endfunction

  function automatic vec_t mk(logic r, logic ir, logic [31:0] ia, logic fl, logic dr,
                              logic [31:0] ra, logic dw, logic [31:0] wa, logic [31:0] wd,
                              logic [3:0] ws, logic [2:0] g, logic [3:0] we, logic [13:0] ad);
    vec_t v;
    v.r = r; v.ir = ir; v.ia = ia; v.fl = fl; v.dr = dr; v.ra = ra; v.dw = dw;
    v.wa = wa; v.wd = wd; v.ws = ws; v.g = g; v.we = we; v.ad = ad;
    return v;
  endfunction

  initial for (int i = 0; i < 16384; i++) mem[i] = init_word(i);

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic run_vec(string tag, vec_t v);
    rsp_t r, n;
    logic [31:0] w;
    int wi;
    @(negedge clk);
    rst = v.r; if_req = v.ir; if_addr = v.ia; if_flush = v.fl; d_re = v.dr;
    d_raddr = v.ra; d_we = v.dw; d_waddr = v.wa; d_wdata = v.wd; d_wstrb = v.ws;
    #1;
    chk({tag, " gnt"}, {29'd0, if_gnt, d_rgnt, d_wgnt}, {29'd0, v.g});
    chk({tag, " ram_en"}, {31'd0, ram_en}, {31'd0, |v.g});
    chk({tag, " ram_we"}, {28'd0, ram_we}, {28'd0, v.we});
    if (|v.g) chk({tag, " ram_addr"}, {18'd0, ram_addr}, {18'd0, v.ad});
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({tag, " if_rvalid"}, {31'd0, if_rvalid}, {31'd0, r.own == 2'd1 && !v.fl});
      chk({tag, " d_rvalid"}, {31'd0, d_rvalid}, {31'd0, r.own == 2'd2});
      if (r.own == 2'd1 && !v.fl) chk({tag, " if_rdata"}, if_rdata, r.data);
      if (r.own == 2'd2) chk({tag, " d_rdata"}, d_rdata, r.data);
    end
    n.own = v.r ? 2'd0 : v.g[2] ? 2'd1 : v.g[1] ? 2'd2 : 2'd0;
    n.data = (n.own == 2'd1) ? exp_word(int'(v.ia[15:2])) :
             (n.own == 2'd2) ? exp_word(int'(v.ra[15:2])) : 32'd0;
    sb.push_back(n);
    if (v.g[0] && !v.r) begin
      wi = int'(v.wa[15:2]);
      w = exp_word(wi);
      for (int b = 0; b < 4; b++) if (v.ws[b]) w[8*b +: 8] = v.wd[8*b +: 8];
      shadow[wi] = w;
    end
  endtask

  initial begin
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 4'hF, 3'b000, 4'h0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 4'h0, 14'd0));
    vecs.push_back(mk(0, 1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 3'b100, 4'h0, 14'd1));
    vecs.push_back(mk(0, 1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 3'b100, 4'h0, 14'd2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0, 0));
    vecs.push_back(mk(0, 1, 32'hC, 0, 1, 32'h100, 1, 32'h100, 32'hDEADBEEF, 4'hF, 3'b001, 4'hF, 14'h40));
    vecs.push_back(mk(0, 1, 32'hC, 0, 1, 32'h100, 0, 0, 0, 0, 3'b010, 4'h0, 14'h40));
    vecs.push_back(mk(0, 1, 32'hC, 0, 0, 0, 0, 0, 0, 0, 3'b100, 4'h0, 14'd3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 32'h10, 0, 1, 32'h200, 0, 0, 0, 0, 3'b010, 4'h0, 14'h80));
    vecs.push_back(mk(0, 1, 32'h10, 0, 1, 32'h200, 0, 0, 0, 0, 3'b100, 4'h0, 14'd4));
    vecs.push_back(mk(0, 1, 32'h10, 0, 1, 32'h200, 0, 0, 0, 0, 3'b010, 4'h0, 14'h80));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h80, 32'h0000AB00, 4'b0010, 3'b001, 4'b0010, 14'h20));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0, 3'b010, 4'h0, 14'h20));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h84, 32'hFFFFFFFF, 4'b0000, 3'b001, 4'h0, 14'h21));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h84, 0, 0, 0, 0, 3'b010, 4'h0, 14'h21));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0, 0));
    foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

    run_vec("byte_merge_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0, 0));
    chk("byte_merge_word", exp_word(32'h20), 32'h1122AB44);

    run_vec("flush_gnt", mk(0, 1, 32'h0004_0004, 0, 0, 0, 0, 0, 0, 0, 3'b100, 4'h0, 14'd1));
    run_vec("flush_rsp", mk(0, 1, 32'h8, 1, 0, 0, 0, 0, 0, 0, 3'b100, 4'h0, 14'd2));
    run_vec("flush_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0, 0));

    for (int i = 0; i < 3; i++)
      run_vec($sformatf("pre_rst%0d", i), mk(0, 1, 32'h10, 0, 1, 32'h0, 0, 0, 0, 0, 3'b010, 4'h0, 14'd0));
    run_vec("rst_mid", mk(1, 1, 32'h10, 0, 1, 32'h0, 1, 32'h0, 32'h0, 4'hF, 3'b000, 4'h0, 0));
    for (int i = 0; i < 4; i++)
      run_vec($sformatf("post_rst%0d", i), mk(0, 1, 32'h10, 0, 1, 32'h0, 0, 0, 0, 0, 3'b010, 4'h0, 14'd0));
    run_vec("post_rst_force", mk(0, 1, 32'h10, 0, 1, 32'h0, 0, 0, 0, 0, 3'b100, 4'h0, 14'd4));
    run_vec("end_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0, 0));
    run_vec("end_idle2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
